data_mem_responder: RTL and testbench

Memory-side responder for the CPU's load/store port. It owns the data RAM and performs byte-lane store merging for sb/sh/sw. It returns the aligned 32-bit word combinationally for loads; the CPU does the lane extraction and sign extension. It also decodes a small MMIO window containing a console TX FIFO, a status/fault register and a free-running cycle counter.

---
 rtl/data_mem_responder_pkg.sv | 13 +
 rtl/data_mem_responder_byte_fifo.sv | 40 ++++
 rtl/data_mem_responder.sv | 85 ++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared MMIO map and access-size codes
package data_mem_responder_pkg;
  localparam logic [23:0] MMIO_BASE  = 24'hFFFFFF;
  localparam logic [7:0]  OFF_TXDATA = 8'h00;
  localparam logic [7:0]  OFF_STATUS = 8'h04;
  localparam logic [7:0]  OFF_CYCLE  = 8'h08;
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;
endpackage

// File: rtl/data_mem_responder_byte_fifo.sv
// byte_fifo: pointer-plus-count byte FIFO; a push while full is taken only alongside a pop
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;
  assign empty  = r_cnt == '0;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign head   = empty ? 8'h00 : r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= r_rd + AW'(w_pop);
      r_wr  <= r_wr + AW'(w_push);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM with byte-lane store merging plus console/status/cycle MMIO
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [2:0]  funct3,
  output logic [31:0] readData,
  output logic        fault,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_cycle;
  logic          r_fault;
  logic          r_overflow;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_off;
  size_e         w_sz;
  logic          w_mmio;
  logic          w_misalign;
  logic          w_ram_we;
  logic          w_tx_wr;
  logic          w_status_wr;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf_set;
  logic          w_unused;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata;
  logic [31:0]   w_mmio_rd;
  assign w_mmio      = address[31:8] == MMIO_BASE;
  assign w_idx       = address[AW+1:2];
  assign w_off       = address[7:0];
  assign w_sz        = size_e'(funct3[1:0]);
  assign w_misalign  = (w_sz == SZ_H && address[0]) || (w_sz == SZ_W && address[1:0] != 2'b00) || w_sz == SZ_X;
  assign w_mask      = w_sz == SZ_B ? 4'b0001 << address[1:0] : w_sz == SZ_H ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata     = w_sz == SZ_B ? {4{writeData[7:0]}} : w_sz == SZ_H ? {2{writeData[15:0]}} : writeData;
  assign w_ram_we    = MemWrite && !w_mmio && !w_misalign;
  assign w_tx_wr     = MemWrite && w_mmio && w_off == OFF_TXDATA;
  assign w_status_wr = MemWrite && w_mmio && w_off == OFF_STATUS;
  assign w_pop       = !w_empty && tx_ready;
  assign w_ovf_set   = w_tx_wr && w_full && !w_pop;
  assign w_mmio_rd   = w_off == OFF_STATUS ? {29'b0, r_overflow, w_full, r_fault} : w_off == OFF_CYCLE ? r_cycle : 32'h0;
  assign readData    = w_mmio ? w_mmio_rd : r_mem[w_idx];
  assign tx_valid    = !w_empty;
  assign fault       = r_fault;
  assign w_unused    = ^{MemRead, funct3[2]};
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_tx_wr),
    .push_data (writeData[7:0]),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (tx_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault    <= 1'b0;
      r_overflow <= 1'b0;
      r_cycle    <= 32'h0;
    end else begin
      r_fault    <= (MemWrite && !w_mmio && w_misalign) || (r_fault && !w_status_wr);
      r_overflow <= w_ovf_set || (r_overflow && !w_status_wr);
      r_cycle    <= r_cycle + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_ram_we)
      for (int i = 0; i < 4; i++)
        if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random traffic against a byte-level reference model plus directed scenarios
module tb_data_mem_responder;
  localparam int DW = 64;
  localparam int FD = 4;
  logic        clk = 0;
  logic        rst = 0;
  logic        MemRead = 0;
  logic        MemWrite = 0;
  logic        tx_ready = 0;
  logic [31:0] address = 0;
  logic [31:0] writeData = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] readData;
  logic        fault;
  logic        tx_valid;
  logic [7:0]  tx_data;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  ref_b [DW*4];
  logic        m_fault = 0;
  logic        m_ovf = 0;
  logic [31:0] m_cycle = 0;
  logic [7:0]  m_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] rd_seen;
  logic [31:0] c1;
  bit          skip_rd = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .address   (address),
    .writeData (writeData),
    .funct3    (funct3),
    .readData  (readData),
    .fault     (fault),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int base;
    if (a[31:8] == 24'hFFFFFF) begin
      if (a[7:0] == 8'h04) return {29'b0, m_ovf, m_q.size() == FD, m_fault};
      if (a[7:0] == 8'h08) return m_cycle;
      return 32'h0;
    end
    base = int'((a >> 2) % DW) * 4;
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  // One access per call: inputs set just after an edge, outputs checked mid-cycle, model committed at the edge.
  task automatic do_cycle(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3, input bit rdy);
    bit pop;
    bit full;
    int base;
    MemWrite = we;
    MemRead = !we;
    address = a;
    writeData = wd;
    funct3 = f3;
    tx_ready = rdy;
    #2;
    rd_seen = readData;
    if (!skip_rd) chk("readData", readData, exp_rd(a));
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    chk("fault", 32'(fault), 32'(m_fault));
    pop = m_q.size() != 0 && rdy;
    full = m_q.size() == FD;
    if (pop) got_q.push_back(tx_data);
    @(posedge clk);
    m_cycle++;
    if (pop) void'(m_q.pop_front());
    if (we && a[31:8] == 24'hFFFFFF) begin
      if (a[7:0] == 8'h00) begin
        if (!full || pop) m_q.push_back(wd[7:0]);
        else m_ovf = 1;
      end
      if (a[7:0] == 8'h04) begin
        m_fault = 0;
        m_ovf = 0;
      end
    end else if (we) begin
      base = int'((a >> 2) % DW) * 4;
      if (f3[1:0] == 2'b00) ref_b[base + int'(a[1:0])] = wd[7:0];
      else if (f3[1:0] == 2'b01 && !a[0]) begin
        ref_b[base + 2*int'(a[1])] = wd[7:0];
        ref_b[base + 2*int'(a[1]) + 1] = wd[15:8];
      end else if (f3[1:0] == 2'b10 && a[1:0] == 2'b00) begin
        for (int i = 0; i < 4; i++) ref_b[base + i] = wd[8*i +: 8];
      end else m_fault = 1;
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    address = 32'hFFFFFF04;
    #1 chk("rst_status", readData, 32'h0);
    address = 32'hFFFFFF08;
    #1 chk("rst_cycle", readData, 32'h0);
    @(posedge clk);
    #1 rst = 1;
    skip_rd = 1;
    for (int i = 0; i < DW; i++) do_cycle(1, 32'(i*4), $urandom, 3'b010, 0);
    skip_rd = 0;
    // byte lane merge
    do_cycle(1, 32'h10, 32'h11223344, 3'b010, 0);
    do_cycle(1, 32'h12, 32'h000000AB, 3'b000, 0);
    chk("rd_old", rd_seen, 32'h11223344);
    do_cycle(0, 32'h10, 0, 3'b010, 0);
    chk("sb_lane", rd_seen, 32'h11AB3344);
    chk("sb_fault", 32'(fault), 32'h0);
    // halfword stores
    do_cycle(1, 32'h14, 32'h0, 3'b010, 0);
    do_cycle(1, 32'h16, 32'h1234BEEF, 3'b001, 0);
    do_cycle(0, 32'h14, 0, 3'b010, 0);
    chk("sh_upper", rd_seen, 32'hBEEF0000);
    do_cycle(1, 32'h15, 32'h0000CAFE, 3'b001, 0);
    do_cycle(0, 32'h14, 0, 3'b010, 0);
    chk("sh_mis_keep", rd_seen, 32'hBEEF0000);
    chk("sh_mis_fault", 32'(fault), 32'h1);
    do_cycle(1, 32'hFFFFFF04, 0, 3'b010, 0);
    chk("status_clr", 32'(fault), 32'h0);
    // misaligned and illegal-size word stores
    do_cycle(1, 32'h20, 32'h01020304, 3'b010, 0);
    do_cycle(1, 32'h21, 32'hDEADBEEF, 3'b010, 0);
    do_cycle(0, 32'h20, 0, 3'b010, 0);
    chk("sw_mis_keep", rd_seen, 32'h01020304);
    chk("sw_mis_fault", 32'(fault), 32'h1);
    do_cycle(1, 32'hFFFFFF04, 0, 3'b010, 0);
    do_cycle(1, 32'h20, 32'hDEADBEEF, 3'b011, 0);
    do_cycle(0, 32'h20, 0, 3'b010, 0);
    chk("sz11_keep", rd_seen, 32'h01020304);
    chk("sz11_fault", 32'(fault), 32'h1);
    do_cycle(1, 32'hFFFFFF04, 0, 3'b010, 0);
    // FIFO ordering and overflow
    for (int i = 0; i < 4; i++) do_cycle(1, 32'hFFFFFF00, 32'h41 + 32'(i), 3'b000, 0);
    do_cycle(0, 32'hFFFFFF04, 0, 3'b010, 0);
    chk("status_full", rd_seen, 32'h2);
    do_cycle(1, 32'hFFFFFF00, 32'h45, 3'b000, 0);
    do_cycle(0, 32'hFFFFFF04, 0, 3'b010, 0);
    chk("status_ovf", rd_seen, 32'h6);
    got_q.delete();
    for (int i = 0; i < 4; i++) do_cycle(0, 32'h0, 0, 3'b010, 1);
    chk("drain_cnt", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("drain_byte", 32'(got_q[i]), 32'h41 + 32'(i));
    chk("drain_empty", 32'(tx_valid), 32'h0);
    do_cycle(1, 32'hFFFFFF04, 0, 3'b010, 0);
    // full FIFO with simultaneous pop accepts the push
    for (int i = 0; i < 4; i++) do_cycle(1, 32'hFFFFFF00, 32'h61 + 32'(i), 3'b000, 0);
    got_q.delete();
    do_cycle(1, 32'hFFFFFF00, 32'h55, 3'b000, 1);
    do_cycle(0, 32'hFFFFFF04, 0, 3'b010, 0);
    chk("fullpop_status", rd_seen, 32'h2);
    for (int i = 0; i < 4; i++) do_cycle(0, 32'h0, 0, 3'b010, 1);
    chk("fullpop_cnt", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) chk("fullpop_last", 32'(got_q[4]), 32'h55);
    // cycle counter delta
    do_cycle(0, 32'hFFFFFF08, 0, 3'b010, 0);
    c1 = rd_seen;
    repeat (6) do_cycle(0, 32'h0, 0, 3'b010, 0);
    do_cycle(0, 32'hFFFFFF08, 0, 3'b010, 0);
    chk("cycle_delta", rd_seen - c1, 32'd7);
    // random traffic, slow sink then fast sink
    for (int i = 0; i < 1600; i++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = k < 4 ? $urandom : {24'hFFFFFF, k < 7 ? 8'h00 : k == 7 ? 8'h04 : k == 8 ? 8'h08 : 8'($urandom)};
      do_cycle(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom), i < 800 ? $urandom_range(0, 9) == 0 : $urandom_range(0, 3) != 0);
    end
    // reset mid-stream
    do_cycle(1, 32'hFFFFFF04, 0, 3'b010, 0);
    for (int i = 0; i < 3; i++) do_cycle(1, 32'hFFFFFF00, 32'h71 + 32'(i), 3'b000, 0);
    MemWrite = 0;
    tx_ready = 1;
    rst = 0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_data", 32'(tx_data), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    m_cycle = 0;
    m_fault = 0;
    m_ovf = 0;
    m_q.delete();
    do_cycle(0, 32'hFFFFFF08, 0, 3'b010, 0);
    chk("cycle_after_rst", rd_seen, 32'h0);
    do_cycle(0, 32'hFFFFFF04, 0, 3'b010, 0);
    chk("status_after_rst", rd_seen, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
